// File: rtl/sar_logic_ctrl.sv
// sar_logic_ctrl -- successive-approximation controller for a SAR ADC.
//   Drives the S/H switch and the capacitive-DAC trial code, and resolves one
//   result bit per comparator decision, MSB first.
//   Optional feature macro: SAR_OFFSET_TRIM_EN (adds offset_i; the result is
//   clamp(code - offset, 0, 2^NBITS-1)).
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset
//   start_i      request one conversion (honoured only in IDLE)
//   cont_mode_i  restart automatically after each conversion
//   comp_in_i    comparator, 1 = Vin >= Vdac(dac_code_o)
//   offset_i     signed trim (only with SAR_OFFSET_TRIM_EN)
//   sample_o     S/H switch, high in SAMPLE
//   dac_code_o   trial code to the DAC
//   busy_o       high in SAMPLE/SETTLE/DECIDE
//   result_o     last completed conversion
//   conv_done_o  one-cycle pulse, result_o valid in the same cycle
module sar_logic_ctrl #(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             cont_mode_i,
  input  logic             comp_in_i,
`ifdef SAR_OFFSET_TRIM_EN
  input  logic [NBITS-1:0] offset_i,
`endif
  output logic             sample_o,
  output logic [NBITS-1:0] dac_code_o,
  output logic             busy_o,
  output logic [NBITS-1:0] result_o,
  output logic             conv_done_o
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int IW      = $clog2(NBITS);
  localparam logic [CW-1:0] SAMP_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] SETL_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [IW-1:0] MSB_IDX   = IW'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_SETTLE, S_DECIDE, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NBITS-1:0] dac_q, dac_d;
  logic [NBITS-1:0] res_q, res_d;
  logic [NBITS-1:0] dec_code;   // trial code with the current bit resolved
  logic [NBITS-1:0] res_val;    // value loaded into result on entering DONE

  always_comb begin
    dec_code        = dac_q;
    dec_code[idx_q] = comp_in_i;
  end

`ifdef SAR_OFFSET_TRIM_EN
  // Two guard bits cover both underflow below 0 and overflow past full scale.
  logic signed [NBITS+1:0] diff;
  always_comb begin
    diff = $signed({2'b00, dec_code}) - $signed({{2{offset_i[NBITS-1]}}, offset_i});
    if (diff < 0)
      res_val = '0;
    else if (diff > $signed({2'b00, {NBITS{1'b1}}}))
      res_val = '1;
    else
      res_val = diff[NBITS-1:0];
  end
`else
  assign res_val = dec_code;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dac_d   = dac_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
          dac_d   = '0;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == SAMP_LAST) begin
          cnt_d        = '0;
          idx_d        = MSB_IDX;
          dac_d        = '0;
          dac_d[MSB_IDX] = 1'b1;
          state_d      = (SETTLE_CYCLES == 0) ? S_DECIDE : S_SETTLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETL_LAST) begin
          cnt_d   = '0;
          state_d = S_DECIDE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECIDE: begin
        dac_d = dec_code;
        if (idx_q != '0) begin
          // Next trial bit is set in the same update that resolves this one.
          dac_d[idx_q - IW'(1)] = 1'b1;
          idx_d   = idx_q - IW'(1);
          state_d = (SETTLE_CYCLES == 0) ? S_DECIDE : S_SETTLE;
        end else begin
          res_d   = res_val;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (cont_mode_i) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
          dac_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dac_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dac_q   <= dac_d;
      res_q   <= res_d;
    end
  end

  assign sample_o    = (state_q == S_SAMPLE);
  assign busy_o      = (state_q == S_SAMPLE) || (state_q == S_SETTLE) || (state_q == S_DECIDE);
  assign conv_done_o = (state_q == S_DONE);
  assign dac_code_o  = dac_q;
  assign result_o    = res_q;

endmodule

// File: tb/tb_sar_logic_ctrl.sv
module tb_sar_logic_ctrl;
  logic       clk = 1'b0;
  logic       reset, start, cont_mode;
  logic [7:0] vin;
  logic [7:0] offset;
  logic       sample, busy, conv_done;
  logic [7:0] dac_code, result;
  logic       comp_in;

  int total = 0;
  int bad   = 0;

  // Ideal comparator against the DAC trial code.
  assign comp_in = (vin >= dac_code);

  always #5 clk = ~clk;

  sar_logic_ctrl #(.NBITS(8), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .cont_mode_i (cont_mode),
    .comp_in_i   (comp_in),
`ifdef SAR_OFFSET_TRIM_EN
    .offset_i    (offset),
`endif
    .sample_o    (sample),
    .dac_code_o  (dac_code),
    .busy_o      (busy),
    .result_o    (result),
    .conv_done_o (conv_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result: clamp(vin - signed offset) into the 8-bit range.
  function automatic int exp_result(input logic [7:0] v, input logic [7:0] off);
    int d;
    d = int'(v) - int'($signed(off));
    if (d < 0)   d = 0;
    if (d > 255) d = 255;
    return d;
  endfunction

  // Binary search trial k (MSB first): bits of v above i, with bit i set.
  function automatic int exp_trial(input logic [7:0] v, input int k);
    int i;
    i = 7 - k;
    return ((int'(v) >> (i + 1)) << (i + 1)) | (1 << i);
  endfunction

  // Wait for conv_done, counting edges; returns 999 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    while (!conv_done && n < 100) begin
      step();
      n++;
    end
    if (!conv_done) n = 999;
  endtask

  task automatic run_conv(input logic [7:0] v, input string tag);
    int n, samp;
    int trials[$];
    vin   = v;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0; samp = 0;
    while (!conv_done && n < 100) begin
      if (sample) samp++;
      else if (busy && (trials.size() == 0 || trials[$] != int'(dac_code)))
        trials.push_back(int'(dac_code));
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 18);
    chk({tag, "_result"}, int'(result), exp_result(v, offset));
    chk({tag, "_sample_cycles"}, samp, 2);
    chk({tag, "_ntrials"}, trials.size(), 8);
    for (int k = 0; k < 8 && k < trials.size(); k++)
      chk($sformatf("%s_trial%0d", tag, k), trials[k], exp_trial(v, k));
    step();
    chk({tag, "_done_pulse"}, int'(conv_done), 0);
  endtask

  initial begin
    int n;
    logic [7:0] r;
    reset = 1'b1; start = 1'b0; cont_mode = 1'b0; vin = 8'h00; offset = 8'h00;
    step(); step();
    chk("rst_sample", int'(sample), 0);
    chk("rst_dac", int'(dac_code), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_done", int'(conv_done), 0);
    reset = 1'b0;
    step();

    run_conv(8'hA5, "a5");
    run_conv(8'h00, "zero");
    run_conv(8'hFF, "full");
    for (int j = 0; j < 6; j++) begin
      r = 8'($urandom_range(0, 255));
      run_conv(r, $sformatf("rnd%0d", j));
    end

    // Reset while bit 4 is being decided.
    vin = 8'h5A; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_sample", int'(sample), 0);
    chk("midrst_dac", int'(dac_code), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_done", int'(conv_done), 0);
    n = 0;
    for (int j = 0; j < 25; j++) begin
      if (conv_done || busy) n++;
      step();
    end
    chk("midrst_quiet", n, 0);
    run_conv(8'h5A, "after_rst");

    // Start held high through the conversion, dropped in the DONE cycle.
    vin = 8'h33; start = 1'b1;
    step();
    wait_done(n);
    start = 1'b0;
    chk("hold_latency", n, 18);
    chk("hold_result", int'(result), exp_result(8'h33, offset));
    n = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      if (conv_done || busy) n++;
    end
    chk("hold_no_extra", n, 0);

    // Continuous mode.
    vin = 8'h3C; cont_mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n);
    chk("cont_first", n, 18);
    chk("cont_res0", int'(result), exp_result(8'h3C, offset));
    for (int j = 0; j < 2; j++) begin
      step();
      wait_done(n);
      chk($sformatf("cont_period%0d", j), n + 1, 19);
      chk($sformatf("cont_res%0d", j + 1), int'(result), exp_result(8'h3C, offset));
    end
    step();
    cont_mode = 1'b0;   // dropped mid-conversion: this one still completes
    wait_done(n);
    chk("cont_last_period", n + 1, 19);
    n = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      if (conv_done || busy) n++;
    end
    chk("cont_stop_idle", n, 0);

`ifdef SAR_OFFSET_TRIM_EN
    offset = 8'h20;
    run_conv(8'h10, "trim_low");
    chk("trim_low_val", int'(result), 0);
    offset = 8'hE0;
    run_conv(8'hF0, "trim_high");
    chk("trim_high_val", int'(result), 255);
    offset = 8'h05;
    run_conv(8'h80, "trim_mid");
    chk("trim_mid_val", int'(result), 8'h7B);
    offset = 8'h00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
